// File: rtl/divider_ctrl.sv
// Control sequencer for an N_BITS non-restoring divider datapath: issues load, shift/count,
// add/sub and final correction strobes, then a one-cycle result_valid pulse.
module divider_ctrl #(
  parameter int unsigned N_BITS = 8,
  parameter int unsigned CNT_W  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             div_zero,
  input  logic             sign_rem,
  output logic             load,
  output logic             shift_en,
  output logic             count_en,
  output logic             add_en,
  output logic             sub_en,
  output logic             final_add,
  output logic             busy,
  output logic             result_valid,
  output logic             dbz_err,
  output logic [CNT_W-1:0] iter
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StShift,
    StAddSub,
    StCorrect,
    StDone
  } state_e;

  localparam logic [CNT_W-1:0] LastIter = CNT_W'(N_BITS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] iter_q, iter_d;
  logic             neg_q, neg_d;
  logic             dbz_q, dbz_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      iter_q  <= '0;
      neg_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      neg_q   <= neg_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    neg_d   = neg_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          dbz_d   = div_zero;
          state_d = div_zero ? StDone : StLoad;
        end
      end
      StLoad: begin
        iter_d  = '0;
        state_d = StShift;
      end
      StShift: begin
        // Sign of R before the shift picks add vs sub for this iteration
        neg_d   = sign_rem;
        state_d = StAddSub;
      end
      StAddSub: begin
        if (iter_q == LastIter) begin
          state_d = StCorrect;
        end else begin
          iter_d  = iter_q + 1'b1;
          state_d = StShift;
        end
      end
      StCorrect: state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase

    // Abort overrides every transition and freezes the counters
    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
      iter_d  = iter_q;
      neg_d   = neg_q;
    end
  end

  always_comb begin
    load         = (state_q == StLoad);
    shift_en     = (state_q == StShift);
    count_en     = (state_q == StShift);
    add_en       = (state_q == StAddSub) && neg_q;
    sub_en       = (state_q == StAddSub) && !neg_q;
    final_add    = (state_q == StCorrect);
    busy         = (state_q != StIdle);
    result_valid = (state_q == StDone);
    dbz_err      = (state_q == StDone) && dbz_q;
    iter         = iter_q;
  end

endmodule

// File: tb/tb_divider_ctrl.sv
// Self-checking bench for divider_ctrl: randomized sign patterns checked cycle by cycle against
// an expected strobe schedule derived from the iteration count and latency rules.
module tb_divider_ctrl;

  localparam int unsigned N = 8;

  logic       clk = 1'b0;
  logic       reset, start, abort, div_zero, sign_rem;
  logic       load, shift_en, count_en, add_en, sub_en, final_add;
  logic       busy, result_valid, dbz_err;
  logic [2:0] iter;

  int         checks = 0;
  int         errors = 0;
  logic [2:0] model_iter = 3'd0;

  always #5 clk = ~clk;

  divider_ctrl #(.N_BITS(N), .CNT_W(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .div_zero    (div_zero),
    .sign_rem    (sign_rem),
    .load        (load),
    .shift_en    (shift_en),
    .count_en    (count_en),
    .add_en      (add_en),
    .sub_en      (sub_en),
    .final_add   (final_add),
    .busy        (busy),
    .result_valid(result_valid),
    .dbz_err     (dbz_err),
    .iter        (iter)
  );

  // Bit order: load shift count add sub final busy valid dbz | iter[2:0]
  task automatic check(input string tag, input logic [11:0] exp);
    logic [11:0] obs;
    obs = {load, shift_en, count_en, add_en, sub_en, final_add, busy, result_valid, dbz_err,
           iter};
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Expected outputs in cycle c after start acceptance (c=0 is LOAD)
  function automatic logic [11:0] exp_vec(input int c, input logic [7:0] mask,
                                          input logic [2:0] prev_iter);
    logic [8:0] s;
    logic [2:0] it;
    int         k;
    if (c == 0) begin
      s  = 9'b100000100;
      it = prev_iter;
    end else if (c <= 2 * N) begin
      k  = (c - 1) / 2;
      it = 3'(k);
      if (c % 2 == 1) s = 9'b011000100;
      else            s = mask[k] ? 9'b000100100 : 9'b000010100;
    end else if (c == 2 * N + 1) begin
      s  = 9'b000001100;
      it = 3'(N - 1);
    end else begin
      s  = 9'b000000110;
      it = 3'(N - 1);
    end
    return {s, it};
  endfunction

  task automatic run_op(input logic [7:0] mask, input int restart_c, input int abort_c,
                        input int reset_c, input bit hold, input bit abort_with_start);
    logic [11:0] e;
    logic [2:0]  prev;
    prev     = model_iter;
    start    = 1'b1;
    div_zero = 1'b0;
    abort    = abort_with_start;
    @(posedge clk);
    #1;
    abort = 1'b0;
    if (!hold) start = 1'b0;
    for (int c = 0; c <= 2 * N + 2; c++) begin
      e = exp_vec(c, mask, prev);
      check($sformatf("op_c%0d", c), e);
      if (c == reset_c) begin
        #2 reset = 1'b1;
        #1 check("async_reset", 12'b0);
        @(posedge clk);
        #1;
        reset      = 1'b0;
        model_iter = 3'd0;
        check("post_reset_idle", 12'b0);
        return;
      end
      // Only the value present in SHIFT matters; elsewhere sign_rem is noise
      sign_rem = (c % 2 == 1 && c <= 2 * N) ? mask[(c - 1) / 2] : 1'($urandom_range(1, 0));
      if (c == restart_c) start = 1'b1;
      else if (!hold)     start = 1'b0;
      abort = (c == abort_c);
      @(posedge clk);
      #1;
      abort = 1'b0;
      if (c == abort_c) begin
        start      = 1'b0;
        model_iter = e[2:0];
        check("abort_idle", {9'b0, model_iter});
        @(posedge clk);
        #1;
        check("abort_stays_idle", {9'b0, model_iter});
        return;
      end
    end
    model_iter = 3'(N - 1);
    check("gap_idle", {9'b0, model_iter});
  endtask

  task automatic run_dbz();
    start    = 1'b1;
    div_zero = 1'b1;
    abort    = 1'b0;
    @(posedge clk);
    #1;
    start    = 1'b0;
    div_zero = 1'b0;
    check("dbz_done", {9'b000000111, model_iter});
    @(posedge clk);
    #1;
    check("dbz_idle", {9'b0, model_iter});
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    div_zero = 1'b0;
    sign_rem = 1'b0;
    #2 check("reset_state", 12'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("idle_after_reset", 12'b0);

    // abort alone in IDLE does nothing
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_in_idle", 12'b0);

    run_op(8'h00, -1, -1, -1, 1'b0, 1'b0);
    run_op(8'b0010_0100, -1, -1, -1, 1'b0, 1'b0);
    run_op(8'($urandom), -1, -1, 8, 1'b0, 1'b0);
    run_dbz();
    run_op(8'($urandom), -1, -1, -1, 1'b0, 1'b0);
    run_op(8'($urandom), 9, 14, -1, 1'b0, 1'b0);
    run_op(8'($urandom), -1, -1, -1, 1'b0, 1'b1);
    run_op(8'($urandom), -1, -1, -1, 1'b1, 1'b0);
    run_op(8'($urandom), -1, -1, -1, 1'b1, 1'b0);
    run_op(8'($urandom), -1, -1, -1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run_op(8'($urandom), -1, -1, -1, 1'b0, 1'b0);
    end
    run_dbz();
    run_op(8'hff, -1, -1, -1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
